// File: rtl/pc_sequencer.sv
// pc_sequencer: XM23 front-end fetch address generator with return-address stack.
// Picks true_pc from init / fast-decode / branch revert / link-back and drives bubbles + flush.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   init, pc_init    hold-and-load of the start address
//   pc_next          sequential / predicted next PC from fast decode
//   lbpc             revert target when branch_fail
//   lr               link-back target when the RAS is empty
//   branch_fail      last predicted branch was wrong
//   link_back        return request
//   call_push        push ret_addr onto the RAS
//   ret_addr         return address to push
//   stall_in         any bit freezes the PC in run phase
//   true_pc          registered fetch address
//   decode_disable   bubble counter non-zero
//   redirect         registered one-cycle flush pulse
//   ras_empty        RAS count is zero
//   ras_full         RAS count is RAS_DEPTH
//   ras_overflow     sticky: push while full
module pc_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int STALL_W      = 8,
  parameter int INIT_BUBBLES = 2,
  parameter int RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADDR_W-1:0] pc_init,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [ADDR_W-1:0] lbpc,
  input  logic [ADDR_W-1:0] lr,
  input  logic              branch_fail,
  input  logic              link_back,
  input  logic              call_push,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [STALL_W-1:0] stall_in,
  output logic [ADDR_W-1:0] true_pc,
  output logic              decode_disable,
  output logic              redirect,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] BUB_LOAD = 4'(INIT_BUBBLES);
  localparam logic [3:0] BUB_ONE = 4'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        bub_q, bub_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic              rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic              push_en;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  // head_q is the next free slot; the top entry sits just below it.
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] ras_top;

  logic in_bub;
  logic run_ok;
  logic hold;
  logic take_bf;
  logic take_lb;
  logic take_nx;

  assign top_idx = head_q - PTR_ONE;
  assign ras_top = ras_mem[top_idx];

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  assign in_bub  = ~init & (bub_q != '0);
  assign run_ok  = ~init & (bub_q == '0);
  assign hold    = |stall_in;
  assign take_bf = run_ok & ~hold & branch_fail;
  assign take_lb = run_ok & ~hold & ~branch_fail & link_back;
  assign take_nx = run_ok & ~hold & ~branch_fail & ~link_back;

  always_comb begin
    pc_d    = pc_q;
    bub_d   = bub_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    rd_d    = 1'b0;
    ovf_d   = ovf_q;
    push_en = 1'b0;
    unique case (1'b1)
      init: begin
        pc_d   = pc_init;
        bub_d  = BUB_LOAD;
        cnt_d  = '0;
        head_d = '0;
        ovf_d  = 1'b0;
      end
      in_bub: begin
        bub_d = bub_q - BUB_ONE;
      end
      take_bf: begin
        pc_d = lbpc;
        rd_d = 1'b1;
      end
      take_lb: begin
        rd_d = 1'b1;
        if (ras_empty) begin
          pc_d = lr;
        end else begin
          pc_d   = ras_top;
          cnt_d  = cnt_q - CNT_ONE;
          head_d = top_idx;
        end
      end
      take_nx: begin
        pc_d = pc_next;
        if (call_push) begin
          push_en = 1'b1;
          head_d  = head_q + PTR_ONE;
          // When full, the write lands on the oldest slot.
          if (ras_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      bub_q  <= BUB_LOAD;
      cnt_q  <= '0;
      head_q <= '0;
      rd_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      bub_q  <= bub_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      ras_mem[head_q] <= ret_addr;
    end
  end

  assign true_pc        = pc_q;
  assign decode_disable = (bub_q != '0);
  assign redirect       = rd_q;
  assign ras_overflow   = ovf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus randomized run
// against a queue-based model of the PC sequencer.
module tb_pc_sequencer;

  localparam int AW = 16;
  localparam int SW = 8;
  localparam int IB = 2;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic [AW-1:0] pc_init = '0;
  logic [AW-1:0] pc_next = '0;
  logic [AW-1:0] lbpc = '0;
  logic [AW-1:0] lr = '0;
  logic          branch_fail = 1'b0;
  logic          link_back = 1'b0;
  logic          call_push = 1'b0;
  logic [AW-1:0] ret_addr = '0;
  logic [SW-1:0] stall_in = '0;
  logic [AW-1:0] true_pc;
  logic          decode_disable;
  logic          redirect;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_overflow;

  pc_sequencer #(
    .ADDR_W(AW), .STALL_W(SW),
    .INIT_BUBBLES(IB), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst), .init(init),
    .pc_init(pc_init), .pc_next(pc_next),
    .lbpc(lbpc), .lr(lr),
    .branch_fail(branch_fail),
    .link_back(link_back),
    .call_push(call_push),
    .ret_addr(ret_addr), .stall_in(stall_in),
    .true_pc(true_pc),
    .decode_disable(decode_disable),
    .redirect(redirect),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, init;
    logic [AW-1:0] pc_init, pc_next, lbpc, lr;
    logic          bf, lb, push;
    logic [AW-1:0] ret;
    logic [SW-1:0] stall;
    logic [AW-1:0] e_pc;
    logic          e_dd, e_rd, e_em, e_fu, e_ov;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int          m_bub;
  logic [AW-1:0] m_pc;
  logic        m_rd, m_ovf;
  logic [AW-1:0] m_ras[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(
    input logic r, input logic in,
    input logic [AW-1:0] pi, input logic [AW-1:0] pn,
    input logic [AW-1:0] lp, input logic [AW-1:0] l,
    input logic bf, input logic lb, input logic pu,
    input logic [AW-1:0] ra, input logic [SW-1:0] st,
    input logic [AW-1:0] epc, input logic edd,
    input logic erd, input logic eem,
    input logic efu, input logic eov);
    vec_t v;
    v.rst = r; v.init = in;
    v.pc_init = pi; v.pc_next = pn;
    v.lbpc = lp; v.lr = l;
    v.bf = bf; v.lb = lb; v.push = pu;
    v.ret = ra; v.stall = st;
    v.e_pc = epc; v.e_dd = edd; v.e_rd = erd;
    v.e_em = eem; v.e_fu = efu; v.e_ov = eov;
    tbl.push_back(v);
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = '0; m_bub = IB; m_rd = 1'b0;
      m_ovf = 1'b0; m_ras.delete();
    end else if (init) begin
      m_pc = pc_init; m_bub = IB; m_rd = 1'b0;
      m_ovf = 1'b0; m_ras.delete();
    end else if (m_bub > 0) begin
      m_bub = m_bub - 1; m_rd = 1'b0;
    end else if (stall_in != 0) begin
      m_rd = 1'b0;
    end else if (branch_fail) begin
      m_pc = lbpc; m_rd = 1'b1;
    end else if (link_back) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = lr;
      m_rd = 1'b1;
    end else begin
      m_pc = pc_next; m_rd = 1'b0;
      if (call_push) begin
        if (m_ras.size() == RD) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(ret_addr);
      end
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; init = v.init;
    pc_init = v.pc_init; pc_next = v.pc_next;
    lbpc = v.lbpc; lr = v.lr;
    branch_fail = v.bf; link_back = v.lb;
    call_push = v.push; ret_addr = v.ret;
    stall_in = v.stall;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    vec_t v;
    m_bub = IB; m_pc = '0; m_rd = 1'b0; m_ovf = 1'b0;

    // r in pc_init pc_next lbpc lr bf lb pu ret stall | pc dd rd em fu ov
    add(1,0,16'h0,  16'h0,  16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h0,  1,0,1,0,0);
    add(0,1,16'h100,16'h0,  16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h100,1,0,1,0,0);
    add(0,1,16'h100,16'h0,  16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h100,1,0,1,0,0);
    add(0,1,16'h100,16'h0,  16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h100,1,0,1,0,0);
    add(0,0,16'h0,  16'h102,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h100,1,0,1,0,0);
    add(0,0,16'h0,  16'h102,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h100,0,0,1,0,0);
    add(0,0,16'h0,  16'h102,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h102,0,0,1,0,0);
    add(0,0,16'h0,  16'h104,16'h200,16'h0,  1,0,0,16'h0,  8'h10, 16'h102,0,0,1,0,0);
    add(0,0,16'h0,  16'h104,16'h200,16'h0,  1,0,0,16'h0,  8'h10, 16'h102,0,0,1,0,0);
    add(0,0,16'h0,  16'h104,16'h200,16'h0,  1,0,0,16'h0,  8'h0,  16'h200,0,1,1,0,0);
    add(0,0,16'h0,  16'h204,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h204,0,0,1,0,0);
    add(0,0,16'h0,  16'h206,16'h0,  16'h0,  0,0,1,16'hA00,8'h0,  16'h206,0,0,0,0,0);
    add(0,0,16'h0,  16'h208,16'h0,  16'h0,  0,0,1,16'hB00,8'h0,  16'h208,0,0,0,0,0);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'hB00,0,1,0,0,0);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'hA00,0,1,1,0,0);
    add(0,0,16'h0,  16'h0,  16'h0,  16'hC00,0,1,0,16'h0,  8'h0,  16'hC00,0,1,1,0,0);
    add(0,0,16'h0,  16'h300,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h300,0,0,1,0,0);
    add(0,0,16'h0,  16'h302,16'h0,  16'h0,  0,0,1,16'h10, 8'h0,  16'h302,0,0,0,0,0);
    add(0,0,16'h0,  16'h304,16'h0,  16'h0,  0,0,1,16'h20, 8'h0,  16'h304,0,0,0,0,0);
    add(0,0,16'h0,  16'h306,16'h0,  16'h0,  0,0,1,16'h30, 8'h0,  16'h306,0,0,0,0,0);
    add(0,0,16'h0,  16'h308,16'h0,  16'h0,  0,0,1,16'h40, 8'h0,  16'h308,0,0,0,1,0);
    add(0,0,16'h0,  16'h30A,16'h0,  16'h0,  0,0,1,16'h50, 8'h0,  16'h30A,0,0,0,1,1);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'h50, 0,1,0,0,1);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'h40, 0,1,0,0,1);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'h30, 0,1,0,0,1);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'h20, 0,1,1,0,1);
    add(0,0,16'h0,  16'h400,16'h0,  16'h0,  0,0,1,16'hA00,8'h0,  16'h400,0,0,0,0,1);
    add(0,0,16'h0,  16'h0,  16'h500,16'h0,  1,1,1,16'hBBB,8'h0,  16'h500,0,1,0,0,1);
    add(0,0,16'h0,  16'h0,  16'h0,  16'h0,  0,1,0,16'h0,  8'h0,  16'hA00,0,1,1,0,1);
    add(0,0,16'h0,  16'h600,16'h0,  16'h0,  0,0,1,16'hC0C,8'h0,  16'h600,0,0,0,0,1);
    add(1,0,16'h0,  16'h0,  16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h0,  1,0,1,0,0);
    add(0,0,16'h0,  16'h700,16'h0,  16'h0,  1,0,1,16'h1234,8'h0, 16'h0,  1,0,1,0,0);
    add(1,0,16'h0,  16'h0,  16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h0,  1,0,1,0,0);
    add(0,0,16'h0,  16'h700,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h0,  1,0,1,0,0);
    add(0,0,16'h0,  16'h700,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h0,  0,0,1,0,0);
    add(0,0,16'h0,  16'h710,16'h0,  16'h0,  0,0,0,16'h0,  8'h0,  16'h710,0,0,1,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      chk($sformatf("row%0d pc", i), 32'(true_pc), 32'(tbl[i].e_pc));
      chk($sformatf("row%0d dd", i), 32'(decode_disable), 32'(tbl[i].e_dd));
      chk($sformatf("row%0d redir", i), 32'(redirect), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d empty", i), 32'(ras_empty), 32'(tbl[i].e_em));
      chk($sformatf("row%0d full", i), 32'(ras_full), 32'(tbl[i].e_fu));
      chk($sformatf("row%0d ovf", i), 32'(ras_overflow), 32'(tbl[i].e_ov));
    end

    for (int k = 0; k < 3000; k++) begin
      v.rst = ($urandom_range(0, 199) == 0);
      v.init = ($urandom_range(0, 59) == 0);
      v.pc_init = AW'($urandom);
      v.pc_next = AW'($urandom);
      v.lbpc = AW'($urandom);
      v.lr = AW'($urandom);
      v.bf = ($urandom_range(0, 7) == 0);
      v.lb = ($urandom_range(0, 3) == 0);
      v.push = ($urandom_range(0, 2) == 0);
      v.ret = AW'($urandom);
      v.stall = ($urandom_range(0, 5) == 0) ? SW'($urandom) : '0;
      drive(v);
      chk($sformatf("rnd%0d pc", k), 32'(true_pc), 32'(m_pc));
      chk($sformatf("rnd%0d dd", k), 32'(decode_disable),
          32'(m_bub != 0));
      chk($sformatf("rnd%0d redir", k), 32'(redirect), 32'(m_rd));
      chk($sformatf("rnd%0d empty", k), 32'(ras_empty),
          32'(m_ras.size() == 0));
      chk($sformatf("rnd%0d full", k), 32'(ras_full),
          32'(m_ras.size() == RD));
      chk($sformatf("rnd%0d ovf", k), 32'(ras_overflow), 32'(m_ovf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the XM23 pipeline front end. It generates the fetch address each cycle and selects between several sources: an init load, the fast-decode next PC, a branch-fail revert, and a link-back return. The single link-register input is replaced by an internal return-address stack (RAS) with underflow fallback. It sits between the pipeline controller and the fetch stage, and it also produces the decode-disable and pipeline-flush controls.

## Interface
- ADDR_W, 16, address width in bits
- STALL_W, 8, number of independent stall request bits
- INIT_BUBBLES, 2, cycles decode stays disabled after reset or init release (1..15)
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- init  in  1  initialization hold; loads pc_init every cycle while high
- pc_init  in  ADDR_W  start address (S9 record)
- pc_next  in  ADDR_W  next PC from fast decode
- lbpc  in  ADDR_W  last-branch PC, target on branch_fail
- lr  in  ADDR_W  architectural link register, fallback target when RAS is empty
- branch_fail  in  1  last predicted branch failed
- link_back  in  1  return request (load of mem[FFFF])
- call_push  in  1  call (BL) fetched; push ret_addr
- ret_addr  in  ADDR_W  return address to push
- stall_in  in  STALL_W  any bit set freezes the PC
- true_pc  out  ADDR_W  fetch address
- decode_disable  out  1  high while the bubble counter is non-zero
- redirect  out  1  one-cycle flush pulse after an accepted branch_fail/link_back
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky; a push occurred while full

## Operation
- Reset (rst=1, highest priority): true_pc=0, bubble counter=INIT_BUBBLES, RAS count=0, redirect=0, ras_overflow=0.
  - Resulting outputs: decode_disable=1, ras_empty=1, ras_full=0.
- init=1 (next priority):
  - true_pc<=pc_init every cycle.
  - Counter reloads to INIT_BUBBLES.
  - RAS cleared and ras_overflow cleared.
  - redirect<=0.
- Bubble phase (counter>0, init=0): counter decrements by 1 per cycle; true_pc holds; all requests are ignored, including stall_in.
- Run phase (counter=0). Priority is stall > branch_fail > link_back > normal:
  - **stall** (|stall_in): true_pc holds, RAS unchanged, redirect<=0.
  - **branch_fail**: true_pc<=lbpc, redirect<=1. Any call_push or link_back in the same cycle is discarded; RAS unchanged.
  - **link_back**: true_pc<=RAS top when non-empty (pop: count-1), else true_pc<=lr with no pop. redirect<=1. call_push in the same cycle is discarded.
  - **normal**: true_pc<=pc_next, redirect<=0. If call_push, push ret_addr.
- RAS behaviour:
  - Circular buffer: head pointer of width log2(RAS_DEPTH), count of width log2(RAS_DEPTH)+1.
  - Push when full overwrites the oldest entry, leaves count at RAS_DEPTH, and sets ras_overflow.
  - Pointers wrap modulo RAS_DEPTH.
- ras_empty and ras_full are combinational from count.
- decode_disable = (counter != 0).

## Timing
- true_pc changes only on posedge clk; a request sampled at edge N shows on true_pc after edge N.
- redirect is registered: high for exactly the cycle following the accepting edge. Back-to-back accepted redirects keep it high.
- After init falls: decode_disable stays high for INIT_BUBBLES cycles. The first pc_next is accepted on edge INIT_BUBBLES+1 after the last init-high edge.
- RAS pop data is read from the pre-edge top (no same-cycle bypass of a push, since push and pop are mutually exclusive).
- rst or init asserted mid-operation aborts the bubble countdown and RAS contents on that edge.
- No combinational path from any input to true_pc.

## Test plan
- Reset, then init with pc_init=0x0100 for 3 cycles, then release with pc_next=0x0102:
  - true_pc=0x0100.
  - decode_disable high for 2 cycles after release.
  - true_pc=0x0102 on the 3rd edge.
- Running; stall_in=8'h10 with branch_fail=1 and lbpc=0x0200 for 2 cycles, then stall cleared:
  - true_pc held through the stall.
  - true_pc=0x0200 the next cycle, with redirect pulsing for 1 cycle.
- Push 0x0A00, then 0x0B00; link_back twice; link_back a third time with lr=0x0C00:
  - true_pc sequence 0x0B00, 0x0A00, 0x0C00.
  - ras_empty=1 after the 2nd pop.
- RAS_DEPTH=4, push 5 values 0x10..0x50, pop 4:
  - ras_overflow=1 after the 5th push.
  - Pops return 0x50, 0x40, 0x30, 0x20.
- branch_fail, link_back and call_push in one cycle, with RAS holding 0x0A00:
  - true_pc=lbpc.
  - RAS count unchanged; top still 0x0A00.
- rst asserted mid-bubble with RAS non-empty:
  - true_pc=0, decode_disable=1, ras_empty=1, ras_overflow=0.
